// File: rtl/a_sched_pkg.sv
// Shared types and constants for the A-tile load scheduler.
package a_sched_pkg;

    localparam int DEF_BUF_DEPTH = 64;
    localparam int BUF0_BASE     = 0;
    localparam int BUF1_BASE     = DEF_BUF_DEPTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_NEXT,
        S_WAIT_BUF,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/a_tile_index_walker.sv
// Tile start/size counter: rows outer, cols inner, min() clipping at the edges.
module a_tile_index_walker
    import a_sched_pkg::*;
#(
    parameter int IB = 7
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          init,
    input  logic          step,
    input  logic [IB-1:0] bram_rows,
    input  logic [IB-1:0] bram_cols,
    input  logic [IB-1:0] tile_rows,
    input  logic [IB-1:0] tile_cols,
    output logic [IB-1:0] row_start,
    output logic [IB-1:0] col_start,
    output logic [IB-1:0] row_size,
    output logic [IB-1:0] col_size,
    output logic          last
);

    logic [IB-1:0] rem_r;
    logic [IB-1:0] rem_c;
    logic          row_last;
    logic          col_last;

    // Compare the remainder rather than start+tile so nothing can wrap.
    assign rem_r    = bram_rows - row_start;
    assign rem_c    = bram_cols - col_start;
    assign row_last = rem_r <= tile_rows;
    assign col_last = rem_c <= tile_cols;
    assign row_size = row_last ? rem_r : tile_rows;
    assign col_size = col_last ? rem_c : tile_cols;
    assign last     = row_last && col_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_start <= '0;
            col_start <= '0;
        end else if (init) begin
            row_start <= '0;
            col_start <= '0;
        end else if (step) begin
            if (col_last) begin
                col_start <= '0;
                row_start <= row_start + tile_rows;
            end else begin
                col_start <= col_start + tile_cols;
            end
        end
    end

endmodule

// File: rtl/a_tile_load_scheduler.sv
// Walks A BRAM in tiles, drives the address generator, hands tiles to compute.
// A_TILE_PINGPONG_EN selects two alternating A RAM buffers instead of one.
module a_tile_load_scheduler
    import a_sched_pkg::*;
#(
    parameter int INTEGER_BIT      = 7,
    parameter int A_RAM_ADDR_WIDTH = 7,
    parameter int A_RAM_BUF_DEPTH  = BUF1_BASE
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic                        ws_os,
    input  logic [INTEGER_BIT-1:0]      bram_row_size,
    input  logic [INTEGER_BIT-1:0]      bram_col_size,
    input  logic [INTEGER_BIT-1:0]      tile_row_size,
    input  logic [INTEGER_BIT-1:0]      tile_col_size,
    output logic                        busy,
    output logic                        done,
    output logic                        gen_enable,
    input  logic                        gen_finish,
    output logic                        gen_ws_os,
    output logic [INTEGER_BIT-1:0]      gen_row_size,
    output logic [INTEGER_BIT-1:0]      gen_col_size,
    output logic [INTEGER_BIT-1:0]      gen_row_start,
    output logic [INTEGER_BIT-1:0]      gen_col_start,
    output logic [A_RAM_ADDR_WIDTH-1:0] gen_a_ram_start_addr,
    output logic                        tile_valid,
    output logic [A_RAM_ADDR_WIDTH-1:0] tile_buf_addr,
    output logic [INTEGER_BIT-1:0]      tile_row_size_o,
    output logic [INTEGER_BIT-1:0]      tile_col_size_o,
    input  logic                        tile_ready
);

    localparam int IB = INTEGER_BIT;
    localparam int AW = A_RAM_ADDR_WIDTH;
`ifdef A_TILE_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    state_t        state;
    state_t        state_n;
    logic [IB-1:0] br, bc, tr, tc;
    logic          ws_q;
    logic [1:0]    full;
    logic          fill_ptr;
    logic          rd_ptr;
    logic [IB-1:0] rows_q [2];
    logic [IB-1:0] cols_q [2];
    logic          w_last;
    logic          accept, zero, set_full, take, buf_free;
    logic [1:0]    set_mask, clr_mask;

    assign accept   = (state == S_IDLE) && start;
    assign zero     = (bram_row_size == '0) || (bram_col_size == '0)
                   || (tile_row_size == '0) || (tile_col_size == '0);
    assign set_full = (state == S_LOAD) && gen_finish;
    assign take     = tile_valid && tile_ready;
    assign buf_free = !full[fill_ptr] || (take && (rd_ptr == fill_ptr));
    assign set_mask = {set_full & fill_ptr, set_full & ~fill_ptr};
    assign clr_mask = {take & rd_ptr, take & ~rd_ptr};

    a_tile_index_walker #(.IB(IB)) u_walker (
        .clk       (clk),
        .rstn      (rstn),
        .init      (accept),
        .step      ((state == S_NEXT) && !w_last),
        .bram_rows (br),
        .bram_cols (bc),
        .tile_rows (tr),
        .tile_cols (tc),
        .row_start (gen_row_start),
        .col_start (gen_col_start),
        .row_size  (gen_row_size),
        .col_size  (gen_col_size),
        .last      (w_last)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:     if (start) state_n = zero ? S_DONE : S_LOAD;
            S_LOAD:     if (gen_finish) state_n = S_RELEASE;
            S_RELEASE:  state_n = S_NEXT;
            S_NEXT:     state_n = w_last ? S_DRAIN
                                : (buf_free ? S_LOAD : S_WAIT_BUF);
            S_WAIT_BUF: if (buf_free) state_n = S_LOAD;
            S_DRAIN:    if (full == 2'b00) state_n = S_DONE;
            S_DONE:     state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_comb begin
        gen_enable = (state == S_LOAD);
        done       = (state == S_DONE);
        busy       = (state != S_IDLE);
    end

    // A finished load marks its buffer full on the edge that enters RELEASE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br        <= '0;
            bc        <= '0;
            tr        <= '0;
            tc        <= '0;
            ws_q      <= 1'b0;
            full      <= 2'b00;
            fill_ptr  <= 1'b0;
            rd_ptr    <= 1'b0;
            rows_q[0] <= '0;
            rows_q[1] <= '0;
            cols_q[0] <= '0;
            cols_q[1] <= '0;
        end else begin
            if (accept) begin
                br       <= bram_row_size;
                bc       <= bram_col_size;
                tr       <= tile_row_size;
                tc       <= tile_col_size;
                ws_q     <= ws_os;
                fill_ptr <= 1'b0;
                rd_ptr   <= 1'b0;
            end
            if (set_full) begin
                rows_q[fill_ptr] <= gen_row_size;
                cols_q[fill_ptr] <= gen_col_size;
                fill_ptr         <= PP ? ~fill_ptr : 1'b0;
            end
            if (take) rd_ptr <= PP ? ~rd_ptr : 1'b0;
            full <= (full & ~clr_mask) | set_mask;
        end
    end

    assign gen_ws_os            = ws_q;
    assign gen_a_ram_start_addr = fill_ptr ? AW'(A_RAM_BUF_DEPTH) : AW'(BUF0_BASE);
    assign tile_valid           = full[rd_ptr];
    assign tile_buf_addr        = rd_ptr ? AW'(A_RAM_BUF_DEPTH) : AW'(BUF0_BASE);
    assign tile_row_size_o      = rows_q[rd_ptr];
    assign tile_col_size_o      = cols_q[rd_ptr];

endmodule

// File: tb/tb_a_tile_load_scheduler.sv
// Directed bench for a_tile_load_scheduler with a small address-generator model.
module tb_a_tile_load_scheduler;

`ifdef A_TILE_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       ws_os = 1'b0;
    logic [6:0] brs = '0, bcs = '0, trs = '0, tcs = '0;
    logic       busy, done, gen_enable, gen_finish, gen_ws_os;
    logic [6:0] gen_row_size, gen_col_size, gen_row_start, gen_col_start;
    logic [6:0] gen_a_ram_start_addr, tile_buf_addr;
    logic [6:0] tile_row_size_o, tile_col_size_o;
    logic       tile_valid;
    logic       tile_ready = 1'b1;

    a_tile_load_scheduler dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .start                (start),
        .ws_os                (ws_os),
        .bram_row_size        (brs),
        .bram_col_size        (bcs),
        .tile_row_size        (trs),
        .tile_col_size        (tcs),
        .busy                 (busy),
        .done                 (done),
        .gen_enable           (gen_enable),
        .gen_finish           (gen_finish),
        .gen_ws_os            (gen_ws_os),
        .gen_row_size         (gen_row_size),
        .gen_col_size         (gen_col_size),
        .gen_row_start        (gen_row_start),
        .gen_col_start        (gen_col_start),
        .gen_a_ram_start_addr (gen_a_ram_start_addr),
        .tile_valid           (tile_valid),
        .tile_buf_addr        (tile_buf_addr),
        .tile_row_size_o      (tile_row_size_o),
        .tile_col_size_o      (tile_col_size_o),
        .tile_ready           (tile_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Generator model: finish on the third enabled cycle, cleared by enable low.
    int gcnt = 0;
    always @(posedge clk) gcnt <= gen_enable ? gcnt + 1 : 0;
    assign gen_finish = gen_enable && (gcnt == 2);

    logic [34:0] loads [$];
    logic [20:0] tiles [$];
    int          done_cnt = 0;
    int          en_cycles = 0;
    int          valid_cycles = 0;
    logic        prev_en = 1'b0;
    logic [34:0] hold = '0;
    logic [34:0] cur;

    always @(negedge clk) begin
        cur = {gen_a_ram_start_addr, gen_row_start, gen_col_start,
               gen_row_size, gen_col_size};
        if (gen_enable && prev_en) check("gen_stable", cur, hold);
        if (gen_enable && gen_finish) loads.push_back(cur);
        if (tile_valid && tile_ready)
            tiles.push_back({tile_buf_addr, tile_row_size_o, tile_col_size_o});
        if (done) done_cnt++;
        if (gen_enable) en_cycles++;
        if (tile_valid) valid_cycles++;
        hold    = cur;
        prev_en = gen_enable;
    end

    // {row_start, col_start, rows, cols}
    logic [27:0] e8 [4] = '{{7'd0, 7'd0, 7'd4, 7'd4}, {7'd0, 7'd4, 7'd4, 7'd4},
                            {7'd4, 7'd0, 7'd4, 7'd4}, {7'd4, 7'd4, 7'd4, 7'd4}};
    logic [27:0] e65 [4] = '{{7'd0, 7'd0, 7'd4, 7'd4}, {7'd0, 7'd4, 7'd4, 7'd1},
                             {7'd4, 7'd0, 7'd2, 7'd4}, {7'd4, 7'd4, 7'd2, 7'd1}};

    function automatic logic [6:0] exp_addr(input int k);
        return PP ? 7'((k % 2) * 64) : 7'd0;
    endfunction

    task automatic start_pass(input logic [6:0] r, input logic [6:0] c,
                              input logic [6:0] t_r, input logic [6:0] t_c,
                              input logic ws);
        @(negedge clk);
        brs = r; bcs = c; trs = t_r; tcs = t_c; ws_os = ws;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) check("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_pass(input string tag, input logic [27:0] e [4]);
        check({tag, "_nloads"}, loads.size(), 4);
        check({tag, "_ntiles"}, tiles.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < loads.size())
                check({tag, "_load"}, loads[i], {exp_addr(i), e[i]});
            if (i < tiles.size())
                check({tag, "_tile"}, tiles[i], {exp_addr(i), e[i][13:0]});
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {busy, done, gen_enable, tile_valid, gen_ws_os,
                gen_row_size, gen_col_size, gen_row_start, gen_col_start,
                gen_a_ram_start_addr, tile_buf_addr,
                tile_row_size_o, tile_col_size_o};
    endfunction

    initial begin
        int d0, e0, v0, n;
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        rstn = 1'b1;

        // 8x8 in 4x4 tiles, compute always ready
        loads.delete(); tiles.delete(); d0 = done_cnt;
        start_pass(7'd8, 7'd8, 7'd4, 7'd4, 1'b1);
        check("start_to_en", gen_enable, 1);
        check("ws_forward", gen_ws_os, 1);
        check("busy_run", busy, 1);
        wait_done(400);
        check_pass("m8", e8);
        check("m8_done_once", done_cnt - d0, 1);
        check("m8_idle", busy, 0);

        // 6x5 with clipped edge tiles
        loads.delete(); tiles.delete();
        start_pass(7'd6, 7'd5, 7'd4, 7'd4, 1'b0);
        wait_done(400);
        check_pass("m65", e65);

        // zero size: straight to DONE, no generator or tile activity
        d0 = done_cnt; e0 = en_cycles; v0 = valid_cycles;
        start_pass(7'd0, 7'd8, 7'd4, 7'd4, 1'b0);
        check("zero_done", done, 1);
        @(negedge clk);
        check("zero_done_pulse", done, 0);
        check("zero_idle", busy, 0);
        repeat (3) @(negedge clk);
        check("zero_done_once", done_cnt - d0, 1);
        check("zero_no_en", en_cycles - e0, 0);
        check("zero_no_valid", valid_cycles - v0, 0);

        // compute stalls on tile 0
        loads.delete(); tiles.delete();
        tile_ready = 1'b0;
        start_pass(7'd8, 7'd8, 7'd4, 7'd4, 1'b0);
        n = 0;
        while (!tile_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", tile_valid, 1);
        repeat (20) @(negedge clk);
        check("stall_nloads", loads.size(), PP ? 2 : 1);
        check("stall_last_addr", loads[loads.size() - 1][34:28], PP ? 64 : 0);
        check("stall_en_low", gen_enable, 0);
        check("stall_valid", tile_valid, 1);
        check("stall_buf_addr", tile_buf_addr, 0);
        check("stall_busy", busy, 1);
        tile_ready = 1'b1;
        wait_done(400);
        check_pass("stall", e8);

        // async reset while tile 2 is loading
        loads.delete(); tiles.delete();
        start_pass(7'd8, 7'd8, 7'd4, 7'd4, 1'b1);
        n = 0;
        while (!(loads.size() == 2 && gen_enable) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_t2", gen_row_start, 4);
        #2 rstn = 1'b0;
        #1 check("rst_async_outs", all_outs(), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        loads.delete(); tiles.delete(); d0 = done_cnt;
        start_pass(7'd8, 7'd8, 7'd4, 7'd4, 1'b0);
        check("rst_restart_row", gen_row_start, 0);
        check("rst_restart_col", gen_col_start, 0);
        wait_done(400);
        check_pass("rst", e8);
        check("rst_done_once", done_cnt - d0, 1);

        // start pulsed while busy must be ignored
        loads.delete(); tiles.delete(); d0 = done_cnt;
        start_pass(7'd8, 7'd8, 7'd4, 7'd4, 1'b1);
        repeat (5) @(negedge clk);
        brs = 7'd2; bcs = 7'd2; trs = 7'd2; tcs = 7'd2; ws_os = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ws_held", gen_ws_os, 1);
        wait_done(400);
        check_pass("busy", e8);
        check("busy_done_once", done_cnt - d0, 1);
        check("busy_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
